hdmi_rx_link_ctrl: RTL

Link-bring-up and recovery sequencer for the three-channel TMDS receive path (blue/green/red decoders).
- Holds the decoders in reset, then waits for all channels to report phase-aligned ready, then channel-valid, then stable frames before declaring link-up.
- On alignment error, valid loss or timeout it re-sequences with bounded retries.
- Sits in the pclk domain, between the clock/BUFPLL logic and the decode channels; its link_up output gates downstream consumers of rgb_data.

---
 rtl/hdmi_rx_link_ctrl_pkg.sv | 22 ++
 rtl/hdmi_rx_link_ctrl_tmr.sv | 21 ++
 rtl/hdmi_rx_link_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hdmi_rx_link_ctrl_pkg.sv
// Shared state codes, counter widths and helpers for the HDMI receive link sequencer.
package hdmi_rx_link_ctrl_pkg;

  localparam int TMR_W = 24;
  localparam int CNT_W = 16;
  localparam int RTY_W = 4;
  localparam int FRM_W = 4;

  typedef enum logic [2:0] {
    ST_RST_CH     = 3'd0,
    ST_WAIT_RDY   = 3'd1,
    ST_WAIT_VLD   = 3'd2,
    ST_WAIT_FRAME = 3'd3,
    ST_LOCKED     = 3'd4,
    ST_FAIL       = 3'd5
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hdmi_rx_link_ctrl_tmr.sv
// Clearable 24-bit up-counter with an equality expiry flag against a caller-supplied limit.
module hdmi_rx_link_ctrl_tmr
  import hdmi_rx_link_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic [TMR_W-1:0] i_limit,
  output logic             o_expired
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) r_count <= '0;
    else                  r_count <= r_count + TMR_W'(1);
  end

  assign o_expired = (r_count == i_limit);

endmodule

// File: rtl/hdmi_rx_link_ctrl.sv
// Link bring-up / recovery sequencer for the three TMDS decode channels.
// Outputs are registered from the next state so they line up with the state register.
module hdmi_rx_link_ctrl
  import hdmi_rx_link_ctrl_pkg::*;
#(
  parameter int               RST_CYCLES    = 16,
  parameter int               RDY_TIMEOUT   = 1048575,
  parameter int               FRAME_TIMEOUT = 4194303,
  parameter int               LOCK_FRAMES   = 2,
  parameter int               MAX_RETRY     = 7,
  parameter int               HOLDOFF       = 16777215,
  parameter bit               VS_POL        = 1'b1,
  parameter logic [CNT_W-1:0] ERR_PRESET    = '0
) (
  input  logic             i_pclk,
  input  logic             i_reset,
  input  logic [2:0]       i_rdy,
  input  logic [2:0]       i_vld,
  input  logic [2:0]       i_psalgnerr,
  input  logic             i_vsync,
  output logic             o_chan_rst,
  output logic             o_link_up,
  output logic             o_link_fail,
  output logic [2:0]       o_state,
  output logic [RTY_W-1:0] o_retry_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  state_e           r_state;
  state_e           w_next;
  state_e           w_fail_tgt;
  logic             r_vs_hist;
  logic [FRM_W-1:0] r_frames;
  logic [RTY_W-1:0] r_retry;
  logic [CNT_W-1:0] r_err;
  logic             r_chan_rst;
  logic             r_link_up;
  logic             r_link_fail;

  logic             w_vs_edge;
  logic [FRM_W-1:0] w_frames_inc;
  logic             w_lock;
  logic             w_link_err;
  logic [RTY_W-1:0] w_retry_inc;
  logic             w_fail_path;
  logic             w_retry_clr;
  logic             w_err_inc;
  logic [TMR_W-1:0] w_limit;
  logic             w_expired;
  logic             w_tmr_clr;

  assign w_vs_edge    = (i_vsync == VS_POL) && (r_vs_hist != VS_POL);
  assign w_frames_inc = r_frames + FRM_W'(1);
  assign w_lock       = w_vs_edge && (w_frames_inc == FRM_W'(LOCK_FRAMES));
  assign w_link_err   = (i_vld != 3'b111) || (i_psalgnerr != 3'b000);
  assign w_retry_inc  = r_retry + RTY_W'(1);
  assign w_fail_tgt   = (w_retry_inc == RTY_W'(MAX_RETRY)) ? ST_FAIL : ST_RST_CH;
  assign w_tmr_clr    = (w_next != r_state);

  // RST_CH and FAIL count whole cycles in state, the waits count up to the timeout inclusive.
  always_comb begin
    w_limit = '0;
    case (r_state)
      ST_RST_CH:     w_limit = TMR_W'(RST_CYCLES - 1);
      ST_WAIT_RDY,
      ST_WAIT_VLD:   w_limit = TMR_W'(RDY_TIMEOUT);
      ST_WAIT_FRAME: w_limit = TMR_W'(FRAME_TIMEOUT);
      ST_FAIL:       w_limit = TMR_W'(HOLDOFF - 1);
      default:       w_limit = '0;
    endcase
  end

  hdmi_rx_link_ctrl_tmr u_tmr (
    .i_clk     (i_pclk),
    .i_reset   (i_reset),
    .i_clr     (w_tmr_clr),
    .i_limit   (w_limit),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next      = r_state;
    w_fail_path = 1'b0;
    w_retry_clr = 1'b0;
    w_err_inc   = 1'b0;
    case (r_state)
      ST_RST_CH: begin
        if (w_expired) w_next = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (i_rdy == 3'b111) w_next = ST_WAIT_VLD;
        else if (w_expired)  w_fail_path = 1'b1;
      end
      ST_WAIT_VLD: begin
        if (i_vld == 3'b111) w_next = ST_WAIT_FRAME;
        else if (w_expired)  w_fail_path = 1'b1;
      end
      ST_WAIT_FRAME: begin
        if (w_link_err) begin
          w_fail_path = 1'b1;
        end else if (w_lock) begin
          w_next      = ST_LOCKED;
          w_retry_clr = 1'b1;
        end else if (w_expired) begin
          w_fail_path = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_link_err) begin
          w_next    = ST_RST_CH;
          w_err_inc = 1'b1;
        end
      end
      ST_FAIL: begin
        if (w_expired) begin
          w_next      = ST_RST_CH;
          w_retry_clr = 1'b1;
        end
      end
      default: w_next = ST_RST_CH;
    endcase
    if (w_fail_path) w_next = w_fail_tgt;
  end

  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      r_state     <= ST_RST_CH;
      r_chan_rst  <= 1'b1;
      r_link_up   <= 1'b0;
      r_link_fail <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_chan_rst  <= (w_next == ST_RST_CH) || (w_next == ST_FAIL);
      r_link_up   <= (w_next == ST_LOCKED);
      r_link_fail <= (w_next == ST_FAIL);
    end
  end

  // Vsync history runs every cycle; edges only advance the frame count inside WAIT_FRAME.
  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      r_vs_hist <= ~VS_POL;
      r_frames  <= '0;
    end else begin
      r_vs_hist <= i_vsync;
      if ((w_next == ST_WAIT_FRAME) && (r_state != ST_WAIT_FRAME))
        r_frames <= '0;
      else if ((r_state == ST_WAIT_FRAME) && w_vs_edge)
        r_frames <= w_frames_inc;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      r_retry <= '0;
      r_err   <= ERR_PRESET;
    end else begin
      if (w_retry_clr)      r_retry <= '0;
      else if (w_fail_path) r_retry <= w_retry_inc;
      if (w_err_inc)        r_err   <= sat_inc(r_err);
    end
  end

  assign o_state     = r_state;
  assign o_chan_rst  = r_chan_rst;
  assign o_link_up   = r_link_up;
  assign o_link_fail = r_link_fail;
  assign o_retry_cnt = r_retry;
  assign o_err_cnt   = r_err;

endmodule
